// File: rtl/sap1e_pkg.sv
// Shared definitions for the SAP-1E control unit: opcodes, T-state numbers
// and the packed control word exchanged between decoder and sequencer.
package sap1e_pkg;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_STA = 4'h3;
   localparam logic [3:0] OP_LDI = 4'h4;
   localparam logic [3:0] OP_JMP = 4'h5;
   localparam logic [3:0] OP_JC  = 4'h6;
   localparam logic [3:0] OP_JZ  = 4'h7;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [2:0] T0 = 3'd0;
   localparam logic [2:0] T1 = 3'd1;
   localparam logic [2:0] T2 = 3'd2;
   localparam logic [2:0] T3 = 3'd3;
   localparam logic [2:0] T4 = 3'd4;
   localparam logic [2:0] T5 = 3'd5;

   // hlt is an internal request to set the halt latch, not a datapath strobe
   typedef struct packed {
      logic pc_oe;
      logic pc_inc;
      logic pc_set;
      logic mar_ld;
      logic ram_oe;
      logic ram_we;
      logic ir_ld;
      logic ir_oe;
      logic a_ld;
      logic a_oe;
      logic b_ld;
      logic alu_oe;
      logic alu_sub;
      logic flags_ld;
      logic out_ld;
      logic hlt;
   } ctrl_word_t;

   localparam ctrl_word_t CW_NONE = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational microcode ROM: maps (T-state, opcode, flags) to the raw
// control word and flags the final T-state of the current instruction.
module control_decode
   import sap1e_pkg::*;
(
   input  logic [2:0]  step_i,
   input  logic [3:0]  opcode_i,
   input  logic        carry_i,
   input  logic        zero_i,
   output ctrl_word_t  cw_o,
   output logic        last_o
);

   always_comb begin
      cw_o   = CW_NONE;
      last_o = 1'b0;
      case (step_i)
         T0: begin
            cw_o.pc_oe  = 1'b1;
            cw_o.mar_ld = 1'b1;
         end
         T1: begin
            cw_o.ram_oe = 1'b1;
            cw_o.ir_ld  = 1'b1;
            cw_o.pc_inc = 1'b1;
         end
         T2: begin
            last_o = 1'b1;
            case (opcode_i)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  cw_o.ir_oe  = 1'b1;
                  cw_o.mar_ld = 1'b1;
                  last_o      = 1'b0;
               end
               OP_LDI: begin
                  cw_o.ir_oe = 1'b1;
                  cw_o.a_ld  = 1'b1;
               end
               OP_JMP: begin
                  cw_o.ir_oe  = 1'b1;
                  cw_o.pc_set = 1'b1;
               end
               OP_JC: begin
                  cw_o.ir_oe  = carry_i;
                  cw_o.pc_set = carry_i;
               end
               OP_JZ: begin
                  cw_o.ir_oe  = zero_i;
                  cw_o.pc_set = zero_i;
               end
               OP_OUT: begin
                  cw_o.a_oe   = 1'b1;
                  cw_o.out_ld = 1'b1;
               end
               // HLT is not "last": the sequencer parks on T2 once halted
               OP_HLT: begin
                  cw_o.hlt = 1'b1;
                  last_o   = 1'b0;
               end
               default: ;
            endcase
         end
         T3: begin
            last_o = 1'b1;
            case (opcode_i)
               OP_LDA: begin
                  cw_o.ram_oe = 1'b1;
                  cw_o.a_ld   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  cw_o.ram_oe = 1'b1;
                  cw_o.b_ld   = 1'b1;
                  last_o      = 1'b0;
               end
               OP_STA: begin
                  cw_o.a_oe   = 1'b1;
                  cw_o.ram_we = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            last_o = 1'b1;
            if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
               cw_o.alu_oe   = 1'b1;
               cw_o.a_ld     = 1'b1;
               cw_o.flags_ld = 1'b1;
               cw_o.alu_sub  = (opcode_i == OP_SUB);
            end
         end
         // T5 and unused encodings drop straight back to fetch
         default: last_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// SAP-1E T-state sequencer: holds step and halt state and gates the decoded
// control word with run, halt and the post-reset idle cycle.
module control_sequencer
   import sap1e_pkg::*;
#(
   parameter int OPCODE_WIDTH = 4,   // only 4 is supported
   parameter int STEP_WIDTH   = 3    // only 3 is supported
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    run,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    carry_flag,
   input  logic                    zero_flag,
   output logic                    pc_oe,
   output logic                    pc_inc,
   output logic                    pc_set,
   output logic                    mar_ld,
   output logic                    ram_oe,
   output logic                    ram_we,
   output logic                    ir_ld,
   output logic                    ir_oe,
   output logic                    a_ld,
   output logic                    a_oe,
   output logic                    b_ld,
   output logic                    alu_oe,
   output logic                    alu_sub,
   output logic                    flags_ld,
   output logic                    out_ld,
   output logic                    halted,
   output logic [STEP_WIDTH-1:0]   step
);

   logic [STEP_WIDTH-1:0] step_q, step_d;
   logic                  halted_q, halted_d;
   logic                  armed_q, armed_d;
   logic                  active;
   logic                  dec_last;
   ctrl_word_t            dec_cw;
   ctrl_word_t            gated_cw;

   control_decode u_decode (
      .step_i   (step_q),
      .opcode_i (opcode),
      .carry_i  (carry_flag),
      .zero_i   (zero_flag),
      .cw_o     (dec_cw),
      .last_o   (dec_last)
   );

   // armed_q keeps the first cycle after reset idle with step parked at 0
   assign active   = run & ~halted_q & armed_q & ~reset;
   assign gated_cw = active ? dec_cw : CW_NONE;

   always_comb begin
      step_d   = step_q;
      halted_d = halted_q;
      armed_d  = 1'b1;
      if (active) begin
         if (dec_cw.hlt) begin
            halted_d = 1'b1;
         end else if (dec_last) begin
            step_d = '0;
         end else begin
            step_d = step_q + {{(STEP_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         step_q   <= '0;
         halted_q <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         step_q   <= step_d;
         halted_q <= halted_d;
         armed_q  <= armed_d;
      end
   end

   assign pc_oe    = gated_cw.pc_oe;
   assign pc_inc   = gated_cw.pc_inc;
   assign pc_set   = gated_cw.pc_set;
   assign mar_ld   = gated_cw.mar_ld;
   assign ram_oe   = gated_cw.ram_oe;
   assign ram_we   = gated_cw.ram_we;
   assign ir_ld    = gated_cw.ir_ld;
   assign ir_oe    = gated_cw.ir_oe;
   assign a_ld     = gated_cw.a_ld;
   assign a_oe     = gated_cw.a_oe;
   assign b_ld     = gated_cw.b_ld;
   assign alu_oe   = gated_cw.alu_oe;
   assign alu_sub  = gated_cw.alu_sub;
   assign flags_ld = gated_cw.flags_ld;
   assign out_ld   = gated_cw.out_ld;
   assign halted   = halted_q;
   assign step     = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle step/strobes/halt
// records are queued as each cycle is driven and checked at the falling edge.
module tb_control_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       run;
   logic [3:0] opcode;
   logic       carry_flag;
   logic       zero_flag;
   logic       pc_oe, pc_inc, pc_set, mar_ld, ram_oe, ram_we, ir_ld, ir_oe;
   logic       a_ld, a_oe, b_ld, alu_oe, alu_sub, flags_ld, out_ld, halted;
   logic [2:0] step;

   control_sequencer #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .run        (run),
      .opcode     (opcode),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .pc_oe      (pc_oe),
      .pc_inc     (pc_inc),
      .pc_set     (pc_set),
      .mar_ld     (mar_ld),
      .ram_oe     (ram_oe),
      .ram_we     (ram_we),
      .ir_ld      (ir_ld),
      .ir_oe      (ir_oe),
      .a_ld       (a_ld),
      .a_oe       (a_oe),
      .b_ld       (b_ld),
      .alu_oe     (alu_oe),
      .alu_sub    (alu_sub),
      .flags_ld   (flags_ld),
      .out_ld     (out_ld),
      .halted     (halted),
      .step       (step)
   );

   always #5 clock = ~clock;

   localparam logic [14:0] S_PC_OE    = 15'h4000;
   localparam logic [14:0] S_PC_INC   = 15'h2000;
   localparam logic [14:0] S_PC_SET   = 15'h1000;
   localparam logic [14:0] S_MAR_LD   = 15'h0800;
   localparam logic [14:0] S_RAM_OE   = 15'h0400;
   localparam logic [14:0] S_RAM_WE   = 15'h0200;
   localparam logic [14:0] S_IR_LD    = 15'h0100;
   localparam logic [14:0] S_IR_OE    = 15'h0080;
   localparam logic [14:0] S_A_LD     = 15'h0040;
   localparam logic [14:0] S_A_OE     = 15'h0020;
   localparam logic [14:0] S_B_LD     = 15'h0010;
   localparam logic [14:0] S_ALU_OE   = 15'h0008;
   localparam logic [14:0] S_ALU_SUB  = 15'h0004;
   localparam logic [14:0] S_FLAGS_LD = 15'h0002;
   localparam logic [14:0] S_OUT_LD   = 15'h0001;

   wire [14:0] strb = {pc_oe, pc_inc, pc_set, mar_ld, ram_oe, ram_we, ir_ld, ir_oe,
                       a_ld, a_oe, b_ld, alu_oe, alu_sub, flags_ld, out_ld};

   typedef struct {
      logic [2:0]  step;
      logic [14:0] strb;
      logic        halted;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'h0, 4'h3: return 4;
         4'h1, 4'h2: return 5;
         default:    return 3;
      endcase
   endfunction

   function automatic logic [14:0] exp_strobes(input logic [3:0] op, input logic c,
                                               input logic z, input int s);
      logic [14:0] w;
      w = '0;
      case (s)
         0: w = S_PC_OE | S_MAR_LD;
         1: w = S_RAM_OE | S_IR_LD | S_PC_INC;
         2: case (op)
               4'h0, 4'h1, 4'h2, 4'h3: w = S_IR_OE | S_MAR_LD;
               4'h4: w = S_IR_OE | S_A_LD;
               4'h5: w = S_IR_OE | S_PC_SET;
               4'h6: w = c ? (S_IR_OE | S_PC_SET) : 15'h0;
               4'h7: w = z ? (S_IR_OE | S_PC_SET) : 15'h0;
               4'hE: w = S_A_OE | S_OUT_LD;
               default: w = '0;
            endcase
         3: case (op)
               4'h0: w = S_RAM_OE | S_A_LD;
               4'h1, 4'h2: w = S_RAM_OE | S_B_LD;
               4'h3: w = S_A_OE | S_RAM_WE;
               default: w = '0;
            endcase
         4: if (op == 4'h1) w = S_ALU_OE | S_A_LD | S_FLAGS_LD;
            else if (op == 4'h2) w = S_ALU_OE | S_A_LD | S_FLAGS_LD | S_ALU_SUB;
         default: w = '0;
      endcase
      return w;
   endfunction

   task automatic push_exp(input logic [2:0] s, input logic [14:0] w, input logic h);
      exp_t e;
      e.step   = s;
      e.strb   = w;
      e.halted = h;
      sb_q.push_back(e);
   endtask

   // Inputs are already driven for this cycle; compare at the falling edge.
   task automatic check_cycle(input string tag);
      exp_t e;
      @(negedge clock);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_step"}, 32'(step), 32'(e.step));
         check({tag, "_strobes"}, 32'(strb), 32'(e.strb));
         check({tag, "_halted"}, 32'(halted), 32'(e.halted));
      end
      check({tag, "_one_bus_driver"},
            32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1), 32'd1);
      check({tag, "_inc_set_excl"}, 32'(pc_inc & pc_set), 32'd0);
      check({tag, "_we_oe_excl"}, 32'(ram_we & ram_oe), 32'd0);
      check({tag, "_step_max4"}, 32'(step <= 3'd4), 32'd1);
      @(posedge clock);
      #1;
   endtask

   task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                            input int stall_at, input int stall_len);
      int len;
      len        = instr_len(op);
      opcode     = op;
      carry_flag = c;
      zero_flag  = z;
      run        = 1'b1;
      for (int s = 0; s < len; s++) begin
         if (s == stall_at) begin
            run = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               push_exp(3'(s), 15'h0, 1'b0);
               check_cycle("stall");
            end
            run = 1'b1;
         end
         push_exp(3'(s), exp_strobes(op, c, z, s), 1'b0);
         check_cycle($sformatf("op%0h_s%0d", op, s));
      end
      $display("instr op=%h c=%b z=%b cycles=%0d stall=%0d", op, c, z, len,
               (stall_at >= 0) ? stall_len : 0);
   endtask

   // Reset held for one cycle, then the idle cycle before the first fetch.
   task automatic do_reset(input logic [2:0] cur_step, input logic cur_halt);
      reset = 1'b1;
      push_exp(cur_step, 15'h0, cur_halt);
      check_cycle("reset");
      reset = 1'b0;
      push_exp(3'd0, 15'h0, 1'b0);
      check_cycle("post_reset");
      $display("reset from step=%0d halted=%b", cur_step, cur_halt);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] op;
      logic       c, z;
      int         sa, sl;

      reset      = 1'b1;
      run        = 1'b1;
      opcode     = 4'h4;
      carry_flag = 1'b0;
      zero_flag  = 1'b0;
      @(posedge clock);
      #1;
      do_reset(3'd0, 1'b0);

      // Directed instruction coverage
      run_instr(4'h4, 1'b0, 1'b0, -1, 0);
      run_instr(4'h4, 1'b0, 1'b0, -1, 0);
      run_instr(4'h1, 1'b0, 1'b0, -1, 0);
      run_instr(4'h2, 1'b0, 1'b0, -1, 0);
      run_instr(4'h6, 1'b0, 1'b1, -1, 0);
      run_instr(4'h6, 1'b1, 1'b0, -1, 0);
      run_instr(4'h7, 1'b1, 1'b0, -1, 0);
      run_instr(4'h7, 1'b0, 1'b1, -1, 0);
      run_instr(4'h5, 1'b0, 1'b0, -1, 0);
      run_instr(4'h0, 1'b0, 1'b0, -1, 0);
      run_instr(4'h3, 1'b0, 1'b0, -1, 0);
      run_instr(4'hE, 1'b0, 1'b0, -1, 0);
      run_instr(4'h9, 1'b1, 1'b1, -1, 0);
      run_instr(4'h1, 1'b0, 1'b0, 3, 4);

      // Reset abandons an ADD in the middle of execute
      opcode = 4'h1;
      for (int s = 0; s < 2; s++) begin
         push_exp(3'(s), exp_strobes(4'h1, 1'b0, 1'b0, s), 1'b0);
         check_cycle("abort_add");
      end
      do_reset(3'd2, 1'b0);
      run_instr(4'h4, 1'b0, 1'b0, -1, 0);

      // Halt: parks on T2 with no strobes until reset
      run_instr(4'hF, 1'b0, 1'b0, -1, 0);
      for (int k = 0; k < 20; k++) begin
         push_exp(3'd2, 15'h0, 1'b1);
         check_cycle("halted");
      end
      do_reset(3'd2, 1'b1);
      run_instr(4'h4, 1'b0, 1'b0, -1, 0);

      // Random instruction stream with occasional run drops
      for (int i = 0; i < 1000; i++) begin
         op = 4'($urandom_range(0, 14));
         c  = 1'($urandom_range(0, 1));
         z  = 1'($urandom_range(0, 1));
         sa = -1;
         sl = 0;
         if ($urandom_range(0, 7) == 0) begin
            sa = $urandom_range(0, instr_len(op) - 1);
            sl = $urandom_range(1, 3);
         end
         run_instr(op, c, z, sa, sl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
